// File: rtl/bcd_pulse_pkg.sv
// bcd_pulse_pkg: shared FSM encoding and BCD digit constants for the pulse generator.
package bcd_pulse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_ZERO = 4'd0;

endpackage

// File: rtl/bcd_down_counter.sv
// bcd_down_counter: DIGITS-wide BCD register with load, borrow-chain decrement,
// zero flag on the held count and an invalid-digit flag on the load value.
module bcd_down_counter
    import bcd_pulse_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                load_i,
    input  logic                dec_i,
    input  logic [4*DIGITS-1:0] value_i,
    output logic [4*DIGITS-1:0] count_o,
    output logic                zero_o,
    output logic                invalid_o
);

    logic [4*DIGITS-1:0] count_q, count_d, dec_val;
    logic                brw;

    // Count minus one in BCD: a zero digit wraps to 9 and keeps borrowing upward.
    always_comb begin
        dec_val = count_q;
        brw     = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (brw) begin
                if (count_q[4*i +: 4] == BCD_ZERO) begin
                    dec_val[4*i +: 4] = BCD_MAX;
                end else begin
                    dec_val[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                    brw               = 1'b0;
                end
            end
        end
    end

    // Flag a load value that contains any non-decimal digit.
    always_comb begin
        invalid_o = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (value_i[4*i +: 4] > BCD_MAX) invalid_o = 1'b1;
        end
    end

    assign zero_o = (count_q == '0);

    // Load wins over decrement; decrement saturates at zero so the count never wraps.
    always_comb begin
        count_d = count_q;
        if (load_i)                count_d = value_i;
        else if (dec_i && !zero_o) count_d = dec_val;
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (reset_i) count_q <= '0;
        else         count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/bcd_pulse_gen.sv
// bcd_pulse_gen: turns a loaded packed-BCD count into exactly that many pulses,
// HIGH_CYC cycles high and LOW_CYC cycles low each.
// Build option: define BCD_PULSE_ABORT_EN to add abort_i, which ends a burst early.
module bcd_pulse_gen
    import bcd_pulse_pkg::*;
#(
    parameter int DIGITS   = 2,
    parameter int HIGH_CYC = 1,
    parameter int LOW_CYC  = 1
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                start_valid_i,
    output logic                start_ready_o,
    input  logic [4*DIGITS-1:0] bcd_in_i,
`ifdef BCD_PULSE_ABORT_EN
    input  logic                abort_i,
`endif
    output logic                pulse_out_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic [4*DIGITS-1:0] remaining_o
);

    localparam int MAXC = (HIGH_CYC > LOW_CYC) ? HIGH_CYC : LOW_CYC;
    localparam int CW   = $clog2(MAXC) + 1;
    localparam logic [CW-1:0] H_LAST = CW'(HIGH_CYC - 1);
    localparam logic [CW-1:0] L_LAST = CW'(LOW_CYC - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            accept, ld_ok, in_bad, rem_zero;
    logic            high_last, low_last, abort_hit, cnt_dec;
    logic            pulse_out_q, busy_q, done_q, err_q, start_ready_q;
    logic            pulse_out_d, busy_d, done_d, err_d, start_ready_d;

    assign accept    = start_valid_i && (state_q == ST_IDLE);
    assign ld_ok     = accept && !in_bad;
    assign high_last = (state_q == ST_HIGH) && (cnt_q == H_LAST);
    assign low_last  = (state_q == ST_LOW)  && (cnt_q == L_LAST);
`ifdef BCD_PULSE_ABORT_EN
    assign abort_hit = abort_i && ((state_q == ST_HIGH) || (state_q == ST_LOW));
`else
    assign abort_hit = 1'b0;
`endif
    // An aborted pulse is not counted as transmitted.
    assign cnt_dec   = high_last && !abort_hit;

    bcd_down_counter #(.DIGITS(DIGITS)) u_cnt (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .load_i    (ld_ok),
        .dec_i     (cnt_dec),
        .value_i   (bcd_in_i),
        .count_o   (remaining_o),
        .zero_o    (rem_zero),
        .invalid_o (in_bad)
    );

    // State and phase-cycle counter registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state; the phase counter restarts at every phase change.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (ld_ok) state_d = (bcd_in_i == '0) ? ST_DONE : ST_HIGH;
            end
            ST_HIGH: begin
                if (high_last) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end
            end
            ST_LOW: begin
                if (low_last) begin
                    state_d = rem_zero ? ST_DONE : ST_HIGH;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (abort_hit) begin
            state_d = ST_DONE;
            cnt_d   = '0;
        end
    end

    // Outputs decoded from the next state so they can be registered without lag.
    always_comb begin
        pulse_out_d   = (state_d == ST_HIGH);
        busy_d        = (state_d != ST_IDLE);
        done_d        = (state_d == ST_DONE);
        start_ready_d = (state_d == ST_IDLE);
        err_d         = accept && in_bad;
    end

    // Output registers; start_ready is already high in the cycle after reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pulse_out_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            start_ready_q <= 1'b1;
        end else begin
            pulse_out_q   <= pulse_out_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
            start_ready_q <= start_ready_d;
        end
    end

    assign pulse_out_o   = pulse_out_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign start_ready_o = start_ready_q;

endmodule

// File: tb/tb_bcd_pulse_gen.sv
// tb_bcd_pulse_gen: directed cases plus random loads, every cycle compared against
// an arithmetic model (cycles since load -> expected pulse level and remaining count).
module tb_bcd_pulse_gen;

    localparam int DIG = 2;
    localparam int W   = 4 * DIG;
    localparam int HC  = 2;
    localparam int LC  = 3;
    localparam int P   = HC + LC;
`ifdef BCD_PULSE_ABORT_EN
    localparam bit ABORT_ON = 1'b1;
`else
    localparam bit ABORT_ON = 1'b0;
`endif

    logic         clk = 1'b0, reset = 1'b1, sv = 1'b0, abort = 1'b0;
    logic [W-1:0] bcd = '0;
    logic         ready, pulse, busy, done, err;
    logic [W-1:0] rem;

    int total = 0, bad = 0;
    // model: mode 0 idle, 1 in burst at cycle m_k (1-based since load), 2 done cycle
    int m_mode = 0, m_k = 0, m_n = 0, m_rem = 0;
    bit m_err = 1'b0;
    int pcount = 0;
    logic prev_pulse = 1'b0;

    always #5 clk = ~clk;

    bcd_pulse_gen #(.DIGITS(DIG), .HIGH_CYC(HC), .LOW_CYC(LC)) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .start_valid_i (sv),
        .start_ready_o (ready),
        .bcd_in_i      (bcd),
`ifdef BCD_PULSE_ABORT_EN
        .abort_i       (abort),
`endif
        .pulse_out_o   (pulse),
        .busy_o        (busy),
        .done_o        (done),
        .err_o         (err),
        .remaining_o   (rem)
    );

    function automatic int bcd2int(input logic [W-1:0] v);
        int r = 0;
        for (int i = DIG - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int x);
        logic [W-1:0] r = '0;
        for (int i = 0; i < DIG; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic bit has_bad(input logic [W-1:0] v);
        for (int i = 0; i < DIG; i++) if (v[4*i +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    // pulses whose high phase has fully elapsed by burst cycle k
    function automatic int compl(input int k);
        return (k - 1 - HC + P) / P;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        m_err = 1'b0;
        if (reset) begin
            m_mode = 0;
            m_rem  = 0;
        end else begin
            case (m_mode)
                0: if (sv) begin
                    if (has_bad(bcd))           m_err = 1'b1;
                    else if (bcd2int(bcd) == 0) begin m_mode = 2; m_rem = 0; end
                    else begin m_mode = 1; m_k = 1; m_n = bcd2int(bcd); end
                end
                1: begin
                    if (ABORT_ON && abort)    begin m_mode = 2; m_rem = m_n - compl(m_k); end
                    else if (m_k == m_n * P)  begin m_mode = 2; m_rem = 0; end
                    else m_k++;
                end
                default: m_mode = 0;
            endcase
        end
    endtask

    task automatic compare();
        logic e_pulse, e_busy, e_done, e_ready;
        logic [W-1:0] e_rem;
        e_pulse = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_ready = 1'b0;
        e_rem   = int2bcd(m_rem);
        case (m_mode)
            0: e_ready = 1'b1;
            1: begin
                e_busy  = 1'b1;
                e_pulse = ((m_k - 1) % P) < HC;
                e_rem   = int2bcd(m_n - compl(m_k));
            end
            default: begin e_busy = 1'b1; e_done = 1'b1; end
        endcase
        chk("pulse", pulse, e_pulse);
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        chk("ready", ready, e_ready);
        chk("err", err, m_err);
        chk("remaining", rem, e_rem);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk); #1;
        compare();
        if (pulse === 1'b1 && prev_pulse === 1'b0) pcount++;
        prev_pulse = pulse;
    endtask

    task automatic load(input logic [W-1:0] v);
        sv = 1'b1; bcd = v;
        tick();
        sv = 1'b0;
    endtask

    initial begin
        int c, ndone;
        bit borrow_seen;
        logic [W-1:0] prev_rem;

        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        chk("rst_ready", ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rem", rem, 8'h00);

        // three pulses: high at T+1,T+2; done at T + 3*5 + 1
        load(8'h03);
        chk("t1_hi1", pulse, 1);
        tick(); chk("t1_hi2", pulse, 1);
        tick(); chk("t1_lo", pulse, 0); chk("t1_rem", rem, 8'h02);
        c = 3;
        while (done !== 1'b1 && c < 100) begin tick(); c++; end
        chk("t1_done_cycle", c, 16);
        tick();

        // ten pulses with the 10 -> 09 borrow, exactly one done strobe
        pcount = 0; ndone = 0; borrow_seen = 1'b0;
        load(8'h10);
        prev_rem = rem;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (done === 1'b1) ndone++;
            if (prev_rem == 8'h10 && rem == 8'h09) borrow_seen = 1'b1;
            prev_rem = rem;
        end
        chk("t2_pulses", pcount, 10);
        chk("t2_ndone", ndone, 1);
        chk("t2_borrow", borrow_seen, 1);

        // zero load: done next cycle, no pulse, ready after that
        load(8'h00);
        chk("t3_done", done, 1); chk("t3_pulse", pulse, 0);
        tick();
        chk("t3_ready", ready, 1); chk("t3_done_clr", done, 0);

        // invalid digit: single err strobe, nothing else moves
        load(8'h1A);
        chk("t4_err", err, 1); chk("t4_busy", busy, 0); chk("t4_rem", rem, 8'h00);
        tick();
        chk("t4_err_clr", err, 0); chk("t4_ready", ready, 1);

        // reset during the second high cycle truncates the pulse
        load(8'h05);
        tick(); chk("t5_hi2", pulse, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_pulse", pulse, 0); chk("t5_rem", rem, 8'h00); chk("t5_ready", ready, 1);

        // loopback count of 27 and of the all-nines maximum
        pcount = 0;
        load(8'h27);
        c = 0;
        while (done !== 1'b1 && c < 300) begin tick(); c++; end
        tick();
        chk("t6_units", pcount % 10, 7);
        chk("t6_count", pcount, 27);

        pcount = 0;
        load(8'h99);
        c = 0;
        while (done !== 1'b1 && c < 600) begin tick(); c++; end
        chk("max_count", pcount, 99);
        chk("max_rem", rem, 8'h00);
        tick();

        if (ABORT_ON) begin
            pcount = 0;
            load(8'h27);
            c = 0;
            while (!(pcount == 2 && pulse === 1'b0) && c < 100) begin tick(); c++; end
            abort = 1'b1;
            tick();
            abort = 1'b0;
            chk("abort_done", done, 1);
            chk("abort_rem", rem, 8'h25);
            tick();
        end

        // random traffic, including loads while busy and occasional resets
        for (int i = 0; i < 3000; i++) begin
            int r;
            reset = ($urandom_range(0, 299) == 0);
            sv    = ($urandom_range(0, 3) == 0);
            abort = ABORT_ON && ($urandom_range(0, 39) == 0);
            r = $urandom_range(0, 49);
            if (r < 5)       bcd = '0;
            else if (r < 10) bcd = W'($urandom);
            else if (r == 10) bcd = 8'h99;
            else             bcd = int2bcd($urandom_range(1, 25));
            tick();
        end
        reset = 1'b0; sv = 1'b0; abort = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
